exec_unit: RTL and testbench

//  Multi-cycle execute stage sitting directly upstream of the register file.

---
 rtl/exec_unit.sv | 199 +++++++++++++++++++
 tb/tb_exec_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: ALU, shift and shift-add multiply, feeding the
// register-file write port through a start/busy/done handshake.
module exec_unit #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [D-1:0] dst_addr,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out,
  output logic         acc_write_en,
  output logic         reg_write_en,
  output logic [D-1:0] waddr,
  output logic         carry
);

  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MUL = CW'(W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_MUL    = 3'd2,
    S_WB_ACC = 3'd3,
    S_WB_REG = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  res_q, res_d;   // result / shifter / multiplier low half
  logic [W-1:0]  hi_q, hi_d;     // multiplier high half
  logic [W-1:0]  b_q, b_d;       // latched multiplicand
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [D-1:0]  waddr_q, waddr_d;
  logic [W:0]    mul_sum_s;
  logic [SW-1:0] sh_amt_s;

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    hi_d      = hi_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    waddr_d   = waddr_q;
    sh_amt_s  = reg_in[SW-1:0];
    mul_sum_s = {1'b0, hi_q} + (res_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          waddr_d = dst_addr;
          b_d     = reg_in;
          hi_d    = {W{1'b0}};
          res_d   = acc_in;
          case (op)
            OP_ADD: begin
              {carry_d, res_d} = {1'b0, acc_in} + {1'b0, reg_in};
              state_d = S_WB_ACC;
            end
            OP_SUB: begin
              res_d   = acc_in - reg_in;
              carry_d = (acc_in < reg_in);
              state_d = S_WB_ACC;
            end
            OP_AND: begin
              res_d   = acc_in & reg_in;
              state_d = S_WB_ACC;
            end
            OP_XOR: begin
              res_d   = acc_in ^ reg_in;
              state_d = S_WB_ACC;
            end
            OP_SHL, OP_SHR: begin
              cnt_d = {{(CW-SW){1'b0}}, sh_amt_s};
              if (sh_amt_s == {SW{1'b0}}) begin
                state_d = S_WB_ACC;
              end else begin
                state_d = S_SHIFT;
              end
            end
            OP_MUL: begin
              cnt_d   = CNT_MUL;
              state_d = S_MUL;
            end
            OP_MOV: begin
              state_d = S_WB_REG;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (op_q == OP_SHL) begin
          carry_d = res_q[W-1];
          res_d   = res_q << 1;
        end else begin
          carry_d = res_q[0];
          res_d   = res_q >> 1;
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_WB_ACC;
        end else begin
          state_d = S_SHIFT;
        end
      end

      // Shift-add: add multiplicand into the high half, then shift the pair right.
      S_MUL: begin
        hi_d  = mul_sum_s[W:1];
        res_d = {mul_sum_s[0], res_q[W-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_WB_ACC;
        end else begin
          state_d = S_MUL;
        end
      end

      S_WB_ACC: begin
        if (op_q == OP_MUL) begin
          res_d   = hi_q;
          state_d = S_WB_REG;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WB_REG: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any op in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      res_q   <= {W{1'b0}};
      hi_q    <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      waddr_q <= {D{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      waddr_q <= waddr_d;
    end
  end

  // Moore outputs decoded from registered state only.
  assign busy         = (state_q != S_IDLE);
  assign acc_write_en = (state_q == S_WB_ACC);
  assign reg_write_en = (state_q == S_WB_REG);
  assign done         = ((state_q == S_WB_ACC) && (op_q != OP_MUL)) || (state_q == S_WB_REG);
  assign data_out     = res_q;
  assign waddr        = waddr_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed vectors checked with immediate assertions.
module tb_exec_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] dst_addr = 4'h0;
  logic [7:0] acc_in = 8'h00;
  logic [7:0] reg_in = 8'h00;
  logic       busy, done, acc_write_en, reg_write_en, carry;
  logic [7:0] data_out;
  logic [3:0] waddr;

  int total = 0;
  int bad = 0;

  exec_unit #(.W(8), .D(4)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op), .dst_addr(dst_addr),
    .acc_in(acc_in), .reg_in(reg_in), .busy(busy), .done(done),
    .data_out(data_out), .acc_write_en(acc_write_en), .reg_write_en(reg_write_en),
    .waddr(waddr), .carry(carry)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse start for one edge; returns in cycle 1 of the op.
  task automatic go(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                    input logic [3:0] d);
    op = o; acc_in = a; reg_in = b; dst_addr = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_accwe", 16'(acc_write_en), 16'h0);
    chk("rst_regwe", 16'(reg_write_en), 16'h0);
    chk("rst_carry", 16'(carry), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    chk("rst_waddr", 16'(waddr), 16'h0);
    @(negedge CLK);
    Reset = 1'b0;
    tick();

    // ADD with carry out
    go(3'b000, 8'hF0, 8'h20, 4'h5);
    chk("add_data", 16'(data_out), 16'h0010);
    chk("add_accwe", 16'(acc_write_en), 16'h1);
    chk("add_regwe", 16'(reg_write_en), 16'h0);
    chk("add_carry", 16'(carry), 16'h1);
    chk("add_done", 16'(done), 16'h1);
    chk("add_busy", 16'(busy), 16'h1);
    tick();
    chk("add_idle_busy", 16'(busy), 16'h0);
    chk("add_idle_done", 16'(done), 16'h0);

    // SUB with and without borrow
    go(3'b001, 8'h05, 8'h07, 4'h0);
    chk("sub1_data", 16'(data_out), 16'h00FE);
    chk("sub1_carry", 16'(carry), 16'h1);
    tick();
    go(3'b001, 8'h07, 8'h05, 4'h0);
    chk("sub2_data", 16'(data_out), 16'h0002);
    chk("sub2_carry", 16'(carry), 16'h0);
    tick();

    // ADD FF+01 sets carry, then AND/XOR must leave it set
    go(3'b000, 8'hFF, 8'h01, 4'h0);
    chk("add2_data", 16'(data_out), 16'h0000);
    chk("add2_carry", 16'(carry), 16'h1);
    tick();
    go(3'b010, 8'hF0, 8'h3C, 4'h0);
    chk("and_data", 16'(data_out), 16'h0030);
    chk("and_carry", 16'(carry), 16'h1);
    tick();
    go(3'b011, 8'hF0, 8'h3C, 4'h0);
    chk("xor_data", 16'(data_out), 16'h00CC);
    chk("xor_carry", 16'(carry), 16'h1);
    tick();

    // SHL 81 by 3: done at cycle 4
    go(3'b100, 8'h81, 8'h03, 4'h0);
    chk("shl_c1_busy", 16'(busy), 16'h1);
    chk("shl_c1_done", 16'(done), 16'h0);
    chk("shl_c1_accwe", 16'(acc_write_en), 16'h0);
    tick(); tick();
    chk("shl_c3_done", 16'(done), 16'h0);
    tick();
    chk("shl_c4_done", 16'(done), 16'h1);
    chk("shl_c4_accwe", 16'(acc_write_en), 16'h1);
    chk("shl_data", 16'(data_out), 16'h0008);
    chk("shl_carry", 16'(carry), 16'h0);
    tick();
    chk("shl_c5_busy", 16'(busy), 16'h0);

    // SHR 81 by 1: carry gets the bit shifted out
    go(3'b101, 8'h81, 8'h01, 4'h0);
    chk("shr1_c1_done", 16'(done), 16'h0);
    tick();
    chk("shr1_c2_done", 16'(done), 16'h1);
    chk("shr1_data", 16'(data_out), 16'h0040);
    chk("shr1_carry", 16'(carry), 16'h1);
    tick();

    // SHR by 0 (upper B bits ignored): immediate write, carry held
    go(3'b101, 8'h81, 8'hF8, 4'h0);
    chk("shr0_done", 16'(done), 16'h1);
    chk("shr0_data", 16'(data_out), 16'h0081);
    chk("shr0_carry", 16'(carry), 16'h1);
    tick();

    // MOV to register 7
    go(3'b111, 8'h5A, 8'h00, 4'h7);
    chk("mov_regwe", 16'(reg_write_en), 16'h1);
    chk("mov_accwe", 16'(acc_write_en), 16'h0);
    chk("mov_waddr", 16'(waddr), 16'h0007);
    chk("mov_data", 16'(data_out), 16'h005A);
    chk("mov_done", 16'(done), 16'h1);
    chk("mov_carry", 16'(carry), 16'h1);
    tick();

    // MUL C8*64 = 4E20 with a stray start at cycle 3
    go(3'b110, 8'hC8, 8'h64, 4'h3);
    tick(); tick();
    op = 3'b000; acc_in = 8'h11; reg_in = 8'h22; dst_addr = 4'h9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mul_c8_busy", 16'(busy), 16'h1);
    chk("mul_c8_accwe", 16'(acc_write_en), 16'h0);
    chk("mul_c8_done", 16'(done), 16'h0);
    tick();
    chk("mul_c9_accwe", 16'(acc_write_en), 16'h1);
    chk("mul_c9_regwe", 16'(reg_write_en), 16'h0);
    chk("mul_c9_done", 16'(done), 16'h0);
    chk("mul_c9_data", 16'(data_out), 16'h0020);
    tick();
    chk("mul_c10_regwe", 16'(reg_write_en), 16'h1);
    chk("mul_c10_accwe", 16'(acc_write_en), 16'h0);
    chk("mul_c10_waddr", 16'(waddr), 16'h0003);
    chk("mul_c10_data", 16'(data_out), 16'h004E);
    chk("mul_c10_done", 16'(done), 16'h1);
    chk("mul_carry", 16'(carry), 16'h1);
    tick();
    chk("mul_c11_busy", 16'(busy), 16'h0);
    chk("mul_c11_accwe", 16'(acc_write_en), 16'h0);

    // MUL 03*05 to address 15: low byte then high byte
    go(3'b110, 8'h03, 8'h05, 4'hF);
    repeat (8) tick();
    chk("mul15_lo", 16'(data_out), 16'h000F);
    chk("mul15_lo_we", 16'(acc_write_en), 16'h1);
    tick();
    chk("mul15_hi", 16'(data_out), 16'h0000);
    chk("mul15_waddr", 16'(waddr), 16'h000F);
    tick();

    // Asynchronous reset at cycle 5 of a MUL
    go(3'b110, 8'hC8, 8'h64, 4'h3);
    repeat (4) tick();
    chk("abort_pre_busy", 16'(busy), 16'h1);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_accwe", 16'(acc_write_en), 16'h0);
    chk("abort_regwe", 16'(reg_write_en), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    chk("abort_data", 16'(data_out), 16'h0000);
    @(negedge CLK);
    Reset = 1'b0;
    tick();
    go(3'b000, 8'h01, 8'h01, 4'h0);
    chk("post_add_data", 16'(data_out), 16'h0002);
    chk("post_add_carry", 16'(carry), 16'h0);
    chk("post_add_done", 16'(done), 16'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
